// File: rtl/fpu_arb_pkg.sv
// Shared types and default sizing for the FPU adder arbiter.
// Every module that touches the arbiter state imports this package.
package fpu_arb_pkg;

  localparam int DEFAULT_N_REQ = 3;
  localparam int DEFAULT_WIDTH = 25;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_DONE  = 2'd2
  } arb_state_t;

endpackage : fpu_arb_pkg

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: the first set request bit at or above ptr,
// wrapping around to bit 0.
module rr_priority_pick
  import fpu_arb_pkg::*;
#(
  parameter int N_REQ = DEFAULT_N_REQ,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [IDW-1:0]   id,
  output logic             valid
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    id    = '0;
    valid = 1'b0;
    // Walk from the farthest offset down to 0 so the closest set bit wins last.
    for (int off = N_REQ - 1; off >= 0; off--) begin
      if (req[(int'(ptr) + off) % N_REQ]) begin
        id    = IDW'((int'(ptr) + off) % N_REQ);
        valid = 1'b1;
      end
    end
  end

endmodule : rr_priority_pick

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one REQ/ACK adder among N_REQ FPU requesters.
// Latches the winner's operands, drives the adder handshake, returns Z/COUT with a one-cycle ACK.
module adder_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int N_REQ = DEFAULT_N_REQ,
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic [N_REQ-1:0]       REQ,
  input  logic [N_REQ*WIDTH-1:0] A_IN,
  input  logic [N_REQ*WIDTH-1:0] B_IN,
  output logic [N_REQ-1:0]       ACK,
  output logic [WIDTH-1:0]       Z,
  output logic                   COUT,
  output logic                   BUSY,
  output logic [IDW-1:0]         GRANT_ID,
  output logic [WIDTH-1:0]       ADD_A,
  output logic [WIDTH-1:0]       ADD_B,
  output logic                   ADD_REQ,
  input  logic [WIDTH-1:0]       ADD_Z,
  input  logic                   ADD_COUT,
  input  logic                   ADD_ACK
);

  arb_state_t       state, state_nxt;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   pick_id;
  logic             pick_valid;
  logic [WIDTH-1:0] z_reg;
  logic             cout_reg;
  logic [WIDTH-1:0] a_slice [N_REQ];
  logic [WIDTH-1:0] b_slice [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign a_slice[i] = A_IN[i*WIDTH +: WIDTH];
    assign b_slice[i] = B_IN[i*WIDTH +: WIDTH];
  end

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_pick (
    .req   (REQ),
    .ptr   (ptr),
    .id    (pick_id),
    .valid (pick_valid)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB_IDLE:  if (pick_valid) state_nxt = ARB_ISSUE;
      ARB_ISSUE: if (ADD_ACK)    state_nxt = ARB_DONE;
      ARB_DONE:                  state_nxt = ARB_IDLE;
      default:                   state_nxt = ARB_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= ARB_IDLE;
      ptr      <= '0;
      GRANT_ID <= '0;
      ADD_A    <= '0;
      ADD_B    <= '0;
      z_reg    <= '0;
      cout_reg <= 1'b0;
    end else begin
      state <= state_nxt;
      // Operands are captured only at the grant edge; later A_IN/B_IN changes are ignored.
      if (state == ARB_IDLE && pick_valid) begin
        GRANT_ID <= pick_id;
        ADD_A    <= a_slice[pick_id];
        ADD_B    <= b_slice[pick_id];
      end
      if (state == ARB_ISSUE && ADD_ACK) begin
        z_reg    <= ADD_Z;
        cout_reg <= ADD_COUT;
      end
      if (state == ARB_DONE) begin
        ptr <= (GRANT_ID == IDW'(N_REQ - 1)) ? '0 : GRANT_ID + 1'b1;
      end
    end
  end

  // Handshake and result outputs decode from state, so reset clears them asynchronously.
  always_comb begin
    ACK     = '0;
    Z       = '0;
    COUT    = 1'b0;
    ADD_REQ = (state == ARB_ISSUE);
    BUSY    = (state != ARB_IDLE);
    if (state == ARB_DONE) begin
      ACK[GRANT_ID] = 1'b1;
      Z             = z_reg;
      COUT          = cout_reg;
    end
  end

endmodule : adder_arbiter

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a behavioural single-cycle adder attached.
module tb_adder_arbiter;

  localparam int N = 3;
  localparam int W = 25;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in, b_in;
  logic [N-1:0]   ack;
  logic [W-1:0]   z, add_a, add_b, add_z;
  logic           cout, busy, add_req, add_cout, add_ack;
  logic [IW-1:0]  grant_id;
  logic           stall;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Behavioural adder: combinational ACK whenever it is requested and not stalled.
  assign {add_cout, add_z} = {1'b0, add_a} + {1'b0, add_b};
  assign add_ack = add_req & ~stall;

  adder_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .CLK      (clk),
    .RSTN     (rst_n),
    .REQ      (req),
    .A_IN     (a_in),
    .B_IN     (b_in),
    .ACK      (ack),
    .Z        (z),
    .COUT     (cout),
    .BUSY     (busy),
    .GRANT_ID (grant_id),
    .ADD_A    (add_a),
    .ADD_B    (add_b),
    .ADD_REQ  (add_req),
    .ADD_Z    (add_z),
    .ADD_COUT (add_cout),
    .ADD_ACK  (add_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ack"},  32'(ack), 32'h0);
    check({tag, "_z"},    32'(z), 32'h0);
    check({tag, "_cout"}, 32'(cout), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  logic [W-1:0] fair_sum [N];

  initial begin
    rst_n = 1'b0;
    req   = '0;
    a_in  = '0;
    b_in  = '0;
    stall = 1'b0;
    fair_sum[0] = 25'h11;
    fair_sum[1] = 25'h22;
    fair_sum[2] = 25'h33;

    tick();
    tick();
    check_idle_outputs("rst");
    check("rst_gid",   32'(grant_id), 32'h0);
    check("rst_addreq", 32'(add_req), 32'h0);
    check("rst_adda",  32'(add_a), 32'h0);
    check("rst_addb",  32'(add_b), 32'h0);
    rst_n = 1'b1;
    tick();
    check_idle_outputs("idle0");

    // Single request, no contention
    req = 3'b001;
    set_ops(0, 25'h0FFFFFF, 25'h0000001);
    tick();
    check("t1_addreq", 32'(add_req), 32'h1);
    check("t1_busy",   32'(busy), 32'h1);
    check("t1_adda",   32'(add_a), 32'h0FFFFFF);
    check("t1_addb",   32'(add_b), 32'h0000001);
    check("t1_ack_c1", 32'(ack), 32'h0);
    tick();
    check("t1_ack",    32'(ack), 32'h1);
    check("t1_z",      32'(z), 32'h1000000);
    check("t1_cout",   32'(cout), 32'h0);
    check("t1_busy_d", 32'(busy), 32'h1);
    check("t1_addreq_d", 32'(add_req), 32'h0);
    req = '0;
    tick();
    check_idle_outputs("t1_end");

    // Carry out from requester 1
    req = 3'b010;
    set_ops(1, 25'h1FFFFFF, 25'h0000001);
    tick();
    check("t2_gid", 32'(grant_id), 32'h1);
    tick();
    check("t2_ack",  32'(ack), 32'h2);
    check("t2_z",    32'(z), 32'h0);
    check("t2_cout", 32'(cout), 32'h1);
    req = '0;
    tick();

    // Operand change after grant is ignored
    req = 3'b100;
    set_ops(2, 25'h100, 25'h5);
    tick();
    set_ops(2, 25'h7FFF, 25'h5);
    check("t3_gid",  32'(grant_id), 32'h2);
    check("t3_adda", 32'(add_a), 32'h100);
    tick();
    check("t3_ack",  32'(ack), 32'h4);
    check("t3_z",    32'(z), 32'h105);
    req = '0;
    tick();

    // Fairness with all requesters active; pointer is now 0
    set_ops(0, 25'h10, 25'h1);
    set_ops(1, 25'h20, 25'h2);
    set_ops(2, 25'h30, 25'h3);
    req = 3'b111;
    for (int t = 0; t < 4; t++) begin
      int id;
      id = t % N;
      tick();
      check($sformatf("fair%0d_gid", t), 32'(grant_id), 32'(id));
      check($sformatf("fair%0d_addreq", t), 32'(add_req), 32'h1);
      check($sformatf("fair%0d_noack", t), 32'(ack), 32'h0);
      tick();
      check($sformatf("fair%0d_ack", t), 32'(ack), 32'(1 << id));
      check($sformatf("fair%0d_z", t), 32'(z), 32'(fair_sum[id]));
      req[id] = 1'b0;
      tick();
      check($sformatf("fair%0d_idle", t), 32'(busy), 32'h0);
      if (t < 3) req[id] = 1'b1;
      else req = '0;
    end

    // Stalled adder; pointer is now 1
    stall = 1'b1;
    req = 3'b010;
    tick();
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("stall%0d_addreq", c), 32'(add_req), 32'h1);
      check($sformatf("stall%0d_busy", c), 32'(busy), 32'h1);
      check($sformatf("stall%0d_ack", c), 32'(ack), 32'h0);
    end
    stall = 1'b0;
    tick();
    check("stall_ack", 32'(ack), 32'h2);
    check("stall_z",   32'(z), 32'h22);
    req = '0;
    tick();

    // Reset during ARB_ISSUE; pointer is now 2
    stall = 1'b1;
    req = 3'b001;
    tick();
    check("rmid_addreq_pre", 32'(add_req), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("rmid_async");
    check("rmid_addreq", 32'(add_req), 32'h0);
    check("rmid_gid",    32'(grant_id), 32'h0);
    check("rmid_adda",   32'(add_a), 32'h0);
    req = '0;
    stall = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_idle_outputs("rpost");
    // With the pointer back at 0, requesters 1 and 2 together must pick 1
    req = 3'b110;
    tick();
    check("rptr_gid", 32'(grant_id), 32'h1);
    req = 3'b100;
    tick();
    check("rptr_ack", 32'(ack), 32'h2);
    check("rptr_z",   32'(z), 32'h22);
    tick();
    check("r2_noack", 32'(ack), 32'h0);
    tick();
    check("r2_gid",   32'(grant_id), 32'h2);
    tick();
    check("r2_ack",   32'(ack), 32'h4);
    check("r2_z",     32'(z), 32'h33);
    req = '0;
    tick();
    check_idle_outputs("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_adder_arbiter

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Round-robin arbiter that shares one 25-bit adder datapath (REQ/ACK handshake, single-cycle combinational ACK, one mandatory recovery cycle) among N_REQ FPU requesters, e.g. mantissa add, rounding increment and exponent adjust.
- Latches the winner's operands, sequences the adder handshake, captures Z/COUT and returns them to the winner with a one-cycle ACK pulse.
- Sits between the FPU pipeline controllers and the shared adder instance.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- WIDTH, 25, operand/result width; must match the adder operand width.
- IDW, $clog2(N_REQ), width of the grant index.

Ports:
- CLK  in  1  clock, rising edge.
- RSTN  in  1  reset, asynchronous, active-low.
- REQ  in  N_REQ  per-requester request level.
- A_IN  in  N_REQ*WIDTH  packed operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- B_IN  in  N_REQ*WIDTH  packed operand B, same packing.
- ACK  out  N_REQ  one-hot, one-cycle completion pulse.
- Z  out  WIDTH  result, valid only while any ACK bit is 1.
- COUT  out  1  carry out, valid with ACK.
- BUSY  out  1  high from grant until the ACK cycle, inclusive.
- GRANT_ID  out  IDW  index of the current or last winner.
- ADD_A  out  WIDTH  operand A to the adder.
- ADD_B  out  WIDTH  operand B to the adder.
- ADD_REQ  out  1  request to the adder.
- ADD_Z  in  WIDTH  adder sum.
- ADD_COUT  in  1  adder carry.
- ADD_ACK  in  1  adder acknowledge; combinational in the cycle the adder accepts REQ.

Behaviour:
- Reset (RSTN=0, asynchronous):
  - State goes to ARB_IDLE.
  - ACK=0, Z=0, COUT=0, BUSY=0, GRANT_ID=0, ADD_REQ=0, ADD_A=0, ADD_B=0.
  - Round-robin pointer resets to 0.
  - Because the adder's reset is synchronous, RSTN must stay low across at least one CLK edge.
- States (ArbState): ARB_IDLE, ARB_ISSUE, ARB_DONE.
- ARB_IDLE:
  - If any REQ bit is 1 at the clock edge, pick the first set bit searching upward (with wrap) from the pointer.
  - Register the winner's A/B slices into ADD_A/ADD_B, set GRANT_ID, set BUSY=1, go to ARB_ISSUE.
  - Otherwise stay in ARB_IDLE.
- ARB_ISSUE:
  - ADD_REQ=1 (driven from state), ADD_A/ADD_B held stable.
  - When ADD_ACK=1: capture ADD_Z/ADD_COUT into result registers and go to ARB_DONE.
  - Otherwise hold ARB_ISSUE indefinitely; no timeout.
- ARB_DONE:
  - ADD_REQ=0. This cycle coincides with the adder's recovery cycle.
  - ACK[GRANT_ID]=1 for exactly one cycle; Z/COUT driven from the result registers.
  - Pointer becomes (GRANT_ID+1) mod N_REQ. Go to ARB_IDLE; BUSY drops at that edge.
- Latency: REQ sampled at edge k gives ADD_REQ in cycle k+1 and ACK in cycle k+2. Minimum issue interval is 3 cycles per transaction.
- Requester rule:
  - Hold REQ and operands until ACK is seen.
  - Deassert REQ at the edge where ACK is sampled, so the following ARB_IDLE sees REQ=0.
  - A REQ still high in ARB_IDLE after ACK is treated as a new request.
- Operands are sampled only at the grant edge; later changes to A_IN/B_IN are ignored.
- A winner dropping REQ mid-transaction does not abort; the ACK is still issued.
- ADD_ACK received in ARB_IDLE or ARB_DONE is ignored.
- Simultaneous requests: only one grant per IDLE cycle; losers wait. With all requesters continuously active, each is served within N_REQ transactions.
- Arithmetic: none locally. {COUT,Z} = ADD_A + ADD_B is computed by the adder, with the carry in COUT.
- Z/COUT read 0 whenever ACK=0.

Decomposition:
- Package fpu_arb_pkg: typedef enum ArbState {ARB_IDLE=0, ARB_ISSUE, ARB_DONE}; default N_REQ and WIDTH constants.
- Sub-module rr_priority_pick: combinational. Inputs are the REQ vector and the pointer; outputs are winner index and a valid flag.
- The arbiter owns all registers.

Test Plan:
- Single request, no contention: REQ=3'b001, A=25'h0FFFFFF, B=25'h0000001 → ADD_REQ in cycle 1, ACK=3'b001 in cycle 2, Z=25'h1000000, COUT=0.
- Carry out: REQ[1], A=25'h1FFFFFF, B=25'h0000001 → ACK=3'b010, Z=0, COUT=1.
- Fairness: REQ=3'b111 held, each requester drops REQ one cycle after its ACK and re-raises it → grant order 0,1,2,0, one ACK every 3 cycles, operands routed correctly.
- Operand change after grant: requester 2 changes A_IN in cycle 1 → result uses the operands registered at the grant edge.
- Stalled adder: ADD_ACK held 0 for 5 cycles → ADD_REQ stays 1, BUSY stays 1, no ACK; ADD_ACK=1 → ACK one cycle later.
- Reset mid-operation: RSTN low during ARB_ISSUE for 2 edges → all outputs 0 asynchronously, pointer 0; after release, REQ=3'b100 → granted normally, no stale ACK.
